// File: rtl/sm_seq_pkg.sv
// Shared definitions for the sequence checker: state encodings, output decode
// and the timeout counter width helper.
package sm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_S1    = 3'b001,
        ST_S2    = 3'b010,
        ST_ERROR = 3'b100
    } state_t;

    // Output decode constants, packed as {o1, o2, err}
    localparam logic [2:0] OUT_IDLE  = 3'b000;
    localparam logic [2:0] OUT_S1    = 3'b100;
    localparam logic [2:0] OUT_S2    = 3'b010;
    localparam logic [2:0] OUT_ERROR = 3'b111;

    // Bits needed to count 0..timeout, never less than one
    function automatic int unsigned tmo_width(input int unsigned timeout);
        int unsigned w;
        w = (timeout == 0) ? 1 : $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [2:0] decode(input state_t s);
        logic [2:0] o;
        o = OUT_IDLE;
        case (s)
            ST_S1:    o = OUT_S1;
            ST_S2:    o = OUT_S2;
            ST_ERROR: o = OUT_ERROR;
            default:  o = OUT_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sm_seq_chan.sv
// One channel of the i1/i2 handshake checker: FSM, S1 stall timer,
// saturating error counter and sequence-complete flag.
module sm_seq_chan
    import sm_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned STICKY  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i1,
    input  logic          i2,
    input  logic          err_clr,
    output logic          o1,
    output logic          o2,
    output logic          err,
    output logic          done,
    output logic [CW-1:0] err_cnt
);

    localparam int unsigned     TW       = tmo_width(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nx;
    logic [CW-1:0] cnt_nx;
    logic          tmo_fire;
    logic          err_entry;
    logic          done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            err_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_nx;
            err_cnt <= cnt_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tmo_fire  = 1'b0;
        tmo_nx    = '0;
        cnt_nx    = err_cnt;
        err_entry = 1'b0;
        done_nx   = 1'b0;

        if (TIMEOUT != 0) begin
            tmo_fire = (tmo_cnt == TMO_LAST);
        end

        case (state)
            ST_IDLE: begin
                if (i1) state_nx = i2 ? ST_S1 : ST_ERROR;
            end
            ST_S1: begin
                // i2 takes priority over an expiring timer
                if (i2)            state_nx = i1 ? ST_S2 : ST_ERROR;
                else if (tmo_fire) state_nx = ST_ERROR;
            end
            ST_S2: begin
                if (!i2) state_nx = i1 ? ST_IDLE : ST_ERROR;
            end
            ST_ERROR: begin
                if (!i1 && ((STICKY == 0) || err_clr)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        err_entry = (state != ST_ERROR) && (state_nx == ST_ERROR);
        done_nx   = (state == ST_S2) && (state_nx == ST_IDLE);

        // Timer restarts on every S1 entry and only runs while S1 persists
        if ((TIMEOUT != 0) && (state == ST_S1) && (state_nx == ST_S1)) begin
            tmo_nx = TW'(tmo_cnt + 1'b1);
        end

        // Clear beats a coincident increment
        if (err_clr) begin
            cnt_nx = '0;
        end else if (err_entry && (err_cnt != CNT_MAX)) begin
            cnt_nx = CW'(err_cnt + 1'b1);
        end

        {o1, o2, err} = decode(state);
    end

endmodule

// File: rtl/sm_seq_checker.sv
// Multi-channel sequence checker: NCH independent handshake channels plus a
// combined error flag for the interrupt logic.
module sm_seq_checker
    import sm_seq_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned STICKY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    i1,
    input  logic [NCH-1:0]    i2,
    input  logic [NCH-1:0]    err_clr,
    output logic [NCH-1:0]    o1,
    output logic [NCH-1:0]    o2,
    output logic [NCH-1:0]    err,
    output logic [NCH-1:0]    done,
    output logic [NCH*CW-1:0] err_cnt,
    output logic              any_err
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        sm_seq_chan #(
            .TIMEOUT (TIMEOUT),
            .CW      (CW),
            .STICKY  (STICKY)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i1      (i1[c]),
            .i2      (i2[c]),
            .err_clr (err_clr[c]),
            .o1      (o1[c]),
            .o2      (o2[c]),
            .err     (err[c]),
            .done    (done[c]),
            .err_cnt (err_cnt[c*CW +: CW])
        );
    end

    assign any_err = |err;

endmodule
